ssd_decoder: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display bus driven by the ASM. Samples the time-multiplexed AN/seven_out lines, waits for each digit slot to settle, decodes each segment pattern back to a hex nibble, and reconstructs all four displayed digits. Used for board-to-board loopback of the display bus and as a self-checking monitor in the top-level bench.

---
 rtl/ssd_pkg.sv | 13 +
 rtl/ssd_pattern_decode.sv | 26 ++
 rtl/ssd_decoder.sv | 104 ++++++++++
 tb/tb_ssd_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment display bus decoder
// Contents: active-high segment patterns for hex digits 0..F (a=bit0), the blank
// pattern, the default settle time and the digit-slot index type.
package ssd_pkg;
    localparam int unsigned SETTLE_DEFAULT = 4;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    // Entry n is the pattern of hex digit n; listed F down to 0 so index 0 is "0".
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    typedef logic [1:0] idx_t;
endpackage

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode: maps an active-high 7-segment pattern back to a hex nibble
// Ports: seg_i      active-high segments, a=bit0
//        is_hex_o   pattern is one of the 16 hex glyphs
//        is_blank_o all segments off
//        nibble_o   decoded value, 0 when not a hex glyph
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       is_hex_o,
    output logic       is_blank_o,
    output logic [3:0] nibble_o
);
    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                is_hex_o = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

    assign is_blank_o = seg_i == SEG_BLANK;
endmodule

// File: rtl/ssd_decoder.sv
// ssd_decoder: reconstructs the four digits shown on a multiplexed seven-segment bus
// Ports: clk, rst (async, active-low), clr (sync clear, active-high)
//        AN[3:0] active-low anodes, seven_out[6:0] active-low cathodes (a=bit0)
//        digits[15:0] nibble per slot, digit_valid/illegal per-slot flags
//        frame_done one-cycle pulse per completed frame, frame_count wrapping frame total
module ssd_decoder
    import ssd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  AN,
    input  logic [6:0]  seven_out,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  illegal,
    output logic        frame_done,
    output logic [7:0]  frame_count
);
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        captured_q, captured_d;
    logic [15:0] digits_q;
    logic [3:0]  valid_q, illegal_q, seen_q, seen_d;
    logic        frame_done_q;
    logic [7:0]  frame_count_q;
    logic [3:0]  an_lo;
    logic [6:0]  seg_hi;
    logic        slot_ok, stable, capture, is_hex, is_blank;
    logic [3:0]  nibble;
    idx_t        idx;

    assign an_lo   = ~sync2_q[10:7];
    assign seg_hi  = ~sync2_q[6:0];
    assign slot_ok = $onehot(an_lo);
    assign idx     = an_lo[3] ? 2'd3 : an_lo[2] ? 2'd2 : an_lo[1] ? 2'd1 : 2'd0;
    assign stable  = sync2_q == prev_q;
    // Counter only runs on a stable, single-anode bus; it saturates so a long dwell stays quiet.
    assign cnt_d   = !(stable && slot_ok) ? 8'd0 : (cnt_q == SETTLE) ? cnt_q : cnt_q + 8'd1;
    // Fire on the edge the counter reaches SETTLE so output lands at edge 2+SETTLE after the pin change.
    assign capture    = slot_ok && stable && !captured_q && cnt_d == SETTLE;
    assign captured_d = capture || (stable && captured_q);
    assign seen_d     = seen_q | (4'b0001 << idx);

    ssd_pattern_decode u_dec (
        .seg_i      (seg_hi),
        .is_hex_o   (is_hex),
        .is_blank_o (is_blank),
        .nibble_o   (nibble)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            captured_q    <= 1'b0;
            digits_q      <= '0;
            valid_q       <= '0;
            illegal_q     <= '0;
            seen_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            sync1_q      <= {AN, seven_out};
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            frame_done_q <= 1'b0;
            if (clr) begin
                cnt_q      <= '0;
                captured_q <= 1'b0;
                digits_q   <= '0;
                valid_q    <= '0;
                illegal_q  <= '0;
                seen_q     <= '0;
            end else begin
                cnt_q      <= cnt_d;
                captured_q <= captured_d;
                if (capture) begin
                    digits_q[{idx, 2'b00} +: 4] <= is_hex ? nibble : 4'h0;
                    valid_q[idx]                <= is_hex;
                    illegal_q[idx]              <= !is_hex && !is_blank;
                    seen_q                      <= (&seen_d) ? 4'h0 : seen_d;
                    if (&seen_d) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 8'd1;
                    end
                end
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign illegal     = illegal_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_ssd_decoder.sv
// tb_ssd_decoder: directed and randomized dwells on the display bus against a capture-event model
module tb_ssd_decoder;
    localparam int S = 4;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  AN = 4'hF;
    logic [6:0]  seven_out = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  digit_valid, illegal;
    logic        frame_done;
    logic [7:0]  frame_count;

    ssd_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .AN          (AN),
        .seven_out   (seven_out),
        .digits      (digits),
        .digit_valid (digit_valid),
        .illegal     (illegal),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cy;
        logic [3:0] an;
        logic [6:0] seg;
    } cap_t;

    cap_t       q[$];
    int         cyc = 0, checks = 0, errors = 0, cur_e0 = 0;
    logic [3:0] cur_an = 4'hF;
    logic [6:0] cur_seg = 7'h7F;
    logic [3:0] m_dig [4];
    logic [3:0] m_val, m_ill, m_seen;
    logic       m_fd;
    logic [7:0] m_fc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_digits();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    function automatic bit slot(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val  = '0;
        m_ill  = '0;
        m_seen = '0;
    endtask

    task automatic m_capture(input cap_t c);
        int idx, n;
        logic [6:0] pat;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!c.an[i]) idx = i;
        pat = ~c.seg;
        n = -1;
        for (int i = 0; i < 16; i++) if (HEX[i] == pat) n = i;
        m_dig[idx]  = (n >= 0) ? 4'(n) : 4'h0;
        m_val[idx]  = n >= 0;
        m_ill[idx]  = n < 0 && pat != 7'h00;
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            m_fd = 1'b1;
            m_fc++;
            m_seen = '0;
        end
    endtask

    task automatic push_cap(input int cy);
        cap_t c;
        c.cy  = cy;
        c.an  = cur_an;
        c.seg = cur_seg;
        q.push_back(c);
    endtask

    // One clock edge: apply any model event due on this edge, then compare every output.
    task automatic tick();
        @(posedge clk);
        cyc++;
        m_fd = 1'b0;
        if (clr) begin
            m_clear();
            q.delete();
            if (slot(cur_an)) push_cap(((cyc > cur_e0 + 2) ? cyc : cur_e0 + 2) + S);
        end else if (q.size() > 0 && q[0].cy == cyc) begin
            m_capture(q[0]);
            void'(q.pop_front());
        end
        #1;
        check("digits", digits, m_digits());
        check("digit_valid", 16'(digit_valid), 16'(m_val));
        check("illegal", 16'(illegal), 16'(m_ill));
        check("frame_done", 16'(frame_done), 16'(m_fd));
        check("frame_count", 16'(frame_count), 16'(m_fc));
    endtask

    // A new bus value first sampled at edge e0 is captured at e0+2+S if it is
    // still on the pins through edge e0+S; an older pending capture survives
    // only if it falls no later than e0+1.
    task automatic start_dwell(input logic [3:0] an, input logic [6:0] seg);
        AN      = an;
        seven_out = seg;
        cur_an  = an;
        cur_seg = seg;
        cur_e0  = cyc + 1;
        while (q.size() > 0 && q[$].cy > cur_e0 + 1) void'(q.pop_back());
        if (slot(an)) push_cap(cur_e0 + 2 + S);
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
        start_dwell(an, seg);
        repeat (len) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_digits", digits, 16'h0);
        check("rst_valid", 16'(digit_valid), 16'h0);
        check("rst_illegal", 16'(illegal), 16'h0);
        check("rst_frame_done", 16'(frame_done), 16'h0);
        check("rst_frame_count", 16'(frame_count), 16'h0);
        m_clear();
        m_fc = '0;
        q.delete();
        AN = 4'hF;
        seven_out = 7'h7F;
        cur_an = 4'hF;
        cur_seg = 7'h7F;
        repeat (2) tick();
        rst = 1'b1;
        cur_e0 = cyc + 1;
    endtask

    initial begin
        logic [7:0] fc_before;
        m_clear();
        m_fc = '0;
        m_fd = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        cur_e0 = cyc + 1;
        repeat (2) tick();

        dwell(4'b1110, ~HEX[3], 10);
        dwell(4'b1101, ~HEX[10], 10);
        dwell(4'b1011, ~HEX[0], 10);
        dwell(4'b0111, ~HEX[15], 10);
        check("scan_digits", digits, 16'hF0A3);
        check("scan_valid", 16'(digit_valid), 16'h000F);
        check("scan_count", 16'(frame_count), 16'd1);

        dwell(4'b1110, ~HEX[5], 3);
        dwell(4'b1110, ~HEX[9], 8);
        check("glitch_digit0", 16'(digits[3:0]), 16'h9);

        dwell(4'b1011, 7'b0000000, 10);
        check("eight_valid", 16'(digit_valid[2]), 16'd1);
        check("eight_nibble", 16'(digits[11:8]), 16'h8);
        dwell(4'b1011, 7'b1010101, 10);
        check("illegal_flag", 16'(illegal[2]), 16'd1);
        check("illegal_valid", 16'(digit_valid[2]), 16'd0);
        dwell(4'b1101, 7'b1111111, 10);
        check("blank_valid", 16'(digit_valid[1]), 16'd0);
        check("blank_illegal", 16'(illegal[1]), 16'd0);

        dwell(4'b1100, ~HEX[7], 20);
        dwell(4'b1110, ~HEX[7], 10);
        check("after_multi_digit0", 16'(digits[3:0]), 16'h7);

        start_dwell(4'b1101, ~HEX[2]);
        repeat (8) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_all_digits", digits, 16'h0);
        dwell(4'b1110, ~HEX[1], 10);
        dwell(4'b1101, ~HEX[2], 10);
        dwell(4'b1011, ~HEX[3], 10);
        fc_before = frame_count;
        start_dwell(4'b0111, ~HEX[4]);
        repeat (S + 2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_win_fd", 16'(frame_done), 16'd0);
        check("clr_win_digits", digits, 16'h0);
        check("clr_win_count", 16'(frame_count), 16'(m_fc));
        dwell(4'b1110, ~HEX[6], 10);
        dwell(4'b1101, ~HEX[7], 10);
        dwell(4'b1011, ~HEX[8], 10);
        dwell(4'b0111, ~HEX[9], 10);
        check("clr_next_frame", 16'(frame_count), 16'(fc_before + 8'd1));

        for (int k = 0; k < 300; k++) begin
            logic [3:0] an;
            logic [6:0] sg;
            int len, r, kc;
            do begin
                r = $urandom_range(0, 5);
                an = (r < 4) ? 4'(~(4'b0001 << r)) : 4'($urandom);
                r = $urandom_range(0, 4);
                sg = (r < 3) ? ~HEX[$urandom_range(0, 15)] : (r == 3) ? 7'h7F : 7'($urandom);
            end while ({an, sg} == {cur_an, cur_seg});
            len = $urandom_range(1, 12);
            if (len >= 4 && $urandom_range(0, 7) == 0) begin
                kc = $urandom_range(2, len - 1);
                start_dwell(an, sg);
                repeat (kc) tick();
                clr = 1'b1;
                tick();
                clr = 1'b0;
                repeat (len - kc - 1) tick();
            end else begin
                dwell(an, sg, len);
            end
        end

        do_reset();
        dwell(4'b1110, ~HEX[1], 10);
        dwell(4'b1101, ~HEX[2], 10);
        do_reset();
        dwell(4'b1110, ~HEX[3], 10);
        dwell(4'b1101, ~HEX[4], 10);
        dwell(4'b1011, ~HEX[5], 10);
        check("rst_three_count", 16'(frame_count), 16'd0);
        dwell(4'b0111, ~HEX[6], 10);
        check("rst_four_count", 16'(frame_count), 16'd1);

        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int d = 0; d < 4; d++) begin
                dwell(4'(~(4'b0001 << d)), ~HEX[$urandom_range(0, 15)], S + 1);
                if (f == 255 && d == 0) check("pre_wrap_count", 16'(frame_count), 16'd255);
            end
        end
        repeat (S + 3) tick();
        check("wrap_count", 16'(frame_count), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
